pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 92 +++++++++
 rtl/pipeline_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//
// Purpose: groups the hazard-detection inputs from the pipeline and the
// stall/flush/bubble controls plus statistics returned by the hazard
// controller into one bundle.
//
// Signal summary (direction seen from the hazard controller, modport slave):
//   idex_memread_i   in   ID/EX instruction is a load
//   idex_rt_i        in   destination register of that load
//   ifid_rs_i        in   source register rs of the IF/ID instruction
//   ifid_rt_i        in   source register rt of the IF/ID instruction
//   branch_taken_i   in   branch resolved taken in ID
//   jump_i           in   jump decoded in ID
//   dmem_req_i       in   EX/MEM instruction accesses data memory
//   dmem_ready_i     in   data memory completes the access this cycle
//   stats_clr_i      in   synchronous clear of the performance counters
//   pc_write_o       out  PC update enable
//   ifid_write_o     out  IF/ID register write enable
//   ifid_flush_o     out  IF/ID clear (insert NOP)
//   ctrl_keep_o      out  1 = pass decoded controls, 0 = zero them (bubble)
//   pipe_write_o     out  ID/EX, EX/MEM, MEM/WB write enable
//   mem_timeout_o    out  sticky data-memory timeout flag
//   stall_cnt_o      out  saturating count of cycles with pc_write_o = 0
//   flush_cnt_o      out  saturating count of cycles with ifid_flush_o = 1
//
// master = pipeline side (drives hazard inputs), slave = hazard controller.
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             idex_memread_i;
  logic [4:0]       idex_rt_i;
  logic [4:0]       ifid_rs_i;
  logic [4:0]       ifid_rt_i;
  logic             branch_taken_i;
  logic             jump_i;
  logic             dmem_req_i;
  logic             dmem_ready_i;
  logic             stats_clr_i;

  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             ctrl_keep_o;
  logic             pipe_write_o;
  logic             mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output idex_memread_i,
    output idex_rt_i,
    output ifid_rs_i,
    output ifid_rt_i,
    output branch_taken_i,
    output jump_i,
    output dmem_req_i,
    output dmem_ready_i,
    output stats_clr_i,
    input  pc_write_o,
    input  ifid_write_o,
    input  ifid_flush_o,
    input  ctrl_keep_o,
    input  pipe_write_o,
    input  mem_timeout_o,
    input  stall_cnt_o,
    input  flush_cnt_o
  );

  modport slave (
    input  idex_memread_i,
    input  idex_rt_i,
    input  ifid_rs_i,
    input  ifid_rt_i,
    input  branch_taken_i,
    input  jump_i,
    input  dmem_req_i,
    input  dmem_ready_i,
    input  stats_clr_i,
    output pc_write_o,
    output ifid_write_o,
    output ifid_flush_o,
    output ctrl_keep_o,
    output pipe_write_o,
    output mem_timeout_o,
    output stall_cnt_o,
    output flush_cnt_o
  );

endinterface : pipeline_hazard_ctrl_if

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose: hazard controller for a classic 5-stage pipeline. It freezes the
// whole pipeline while data memory is busy, inserts a one-cycle bubble on a
// load-use dependency, flushes IF/ID on a taken branch or jump, flags a
// data-memory access that waits too long, and keeps saturating stall/flush
// statistics.
//
// Ports:
//   clk_i   single clock, all state updates on the rising edge
//   rst_i   synchronous, active-high reset
//   bus     pipeline_hazard_ctrl_if.slave (hazard inputs, pipeline controls,
//           timeout flag and performance counters)
//
// Parameters:
//   MAX_WAIT  memory wait cycles (1..255) after which the timeout flag sets
//   CNT_W     width of the performance counters
//
// Control outputs are combinational from the current state and inputs so a
// hazard stalls the pipeline in the very cycle it is detected.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pipeline_hazard_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  // Saturating +1 for the performance counters.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  // Saturating +1 for the 8-bit memory wait counter.
  function automatic logic [7:0] sat_inc_wait(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  state_e           state_r;
  state_e           state_nxt_s;
  logic [7:0]       wait_cnt_r;
  logic             timeout_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic             freeze_s;
  logic             load_use_s;
  logic             redirect_s;
  logic             enter_wait_s;
  logic             wait_miss_s;

  logic             pc_write_s;
  logic             ifid_write_s;
  logic             ifid_flush_s;
  logic             ctrl_keep_s;
  logic             pipe_write_s;

  // Hazard detection: a load writing r0 never creates a dependency.
  always_comb begin
    load_use_s = 1'b0;
    redirect_s = 1'b0;
    if (bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
        ((bus.idex_rt_i == bus.ifid_rs_i) || (bus.idex_rt_i == bus.ifid_rt_i))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
    if (bus.branch_taken_i || bus.jump_i) begin
      redirect_s = 1'b1;
    end else begin
      redirect_s = 1'b0;
    end
  end

  // Next-state logic and memory-freeze decode. Once in MEM_WAIT only
  // dmem_ready_i matters; a ready cycle releases the freeze immediately.
  always_comb begin
    state_nxt_s = state_r;
    freeze_s    = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (bus.dmem_req_i && !bus.dmem_ready_i) begin
          freeze_s    = 1'b1;
          state_nxt_s = ST_MEM_WAIT;
        end else begin
          freeze_s    = 1'b0;
          state_nxt_s = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!bus.dmem_ready_i) begin
          freeze_s    = 1'b1;
          state_nxt_s = ST_MEM_WAIT;
        end else begin
          freeze_s    = 1'b0;
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        freeze_s    = 1'b0;
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Pipeline control outputs, priority freeze > load-use > redirect > normal.
  // A redirect under a load-use bubble is dropped on purpose: ID still holds
  // the branch and re-resolves it once the load data is forwarded.
  always_comb begin
    pc_write_s   = 1'b0;
    ifid_write_s = 1'b0;
    ifid_flush_s = 1'b0;
    ctrl_keep_s  = 1'b0;
    pipe_write_s = 1'b0;
    if (rst_i) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      ifid_flush_s = 1'b0;
      ctrl_keep_s  = 1'b0;
      pipe_write_s = 1'b0;
    end else if (freeze_s) begin
      // Whole pipeline holds; controls pass unchanged so nothing is lost.
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      ifid_flush_s = 1'b0;
      ctrl_keep_s  = 1'b1;
      pipe_write_s = 1'b0;
    end else if (load_use_s) begin
      // Hold PC and IF/ID, push a zero-control bubble into ID/EX.
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      ifid_flush_s = 1'b0;
      ctrl_keep_s  = 1'b0;
      pipe_write_s = 1'b1;
    end else if (redirect_s) begin
      pc_write_s   = 1'b1;
      ifid_write_s = 1'b1;
      ifid_flush_s = 1'b1;
      ctrl_keep_s  = 1'b1;
      pipe_write_s = 1'b1;
    end else begin
      pc_write_s   = 1'b1;
      ifid_write_s = 1'b1;
      ifid_flush_s = 1'b0;
      ctrl_keep_s  = 1'b1;
      pipe_write_s = 1'b1;
    end
  end

  // Wait-counter qualifiers: entry into MEM_WAIT and each unserved wait cycle.
  always_comb begin
    enter_wait_s = 1'b0;
    wait_miss_s  = 1'b0;
    if ((state_r == ST_RUN) && (state_nxt_s == ST_MEM_WAIT)) begin
      enter_wait_s = 1'b1;
    end else begin
      enter_wait_s = 1'b0;
    end
    if ((state_r == ST_MEM_WAIT) && !bus.dmem_ready_i) begin
      wait_miss_s = 1'b1;
    end else begin
      wait_miss_s = 1'b0;
    end
  end

  // FSM state register; reset aborts any memory wait in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Wait counter: holds the index of the current MEM_WAIT cycle (1-based).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_r <= 8'd0;
    end else if (enter_wait_s) begin
      wait_cnt_r <= 8'd1;
    end else if (wait_miss_s) begin
      wait_cnt_r <= sat_inc_wait(wait_cnt_r);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Sticky timeout flag; only reset clears it, the freeze itself continues.
  // The MEM_WAIT qualifier keeps a stale count from firing while in RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_r <= 1'b0;
    end else if (wait_miss_s && (wait_cnt_r == MAX_WAIT_C)) begin
      timeout_r <= 1'b1;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  // Performance counters; clear takes precedence over a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else if (bus.stats_clr_i) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (!pc_write_s) begin
        stall_cnt_r <= sat_inc_cnt(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (ifid_flush_s) begin
        flush_cnt_r <= sat_inc_cnt(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bus.pc_write_o    = pc_write_s;
  assign bus.ifid_write_o  = ifid_write_s;
  assign bus.ifid_flush_o  = ifid_flush_s;
  assign bus.ctrl_keep_o   = ctrl_keep_s;
  assign bus.pipe_write_o  = pipe_write_s;
  assign bus.mem_timeout_o = timeout_r;
  assign bus.stall_cnt_o   = stall_cnt_r;
  assign bus.flush_cnt_o   = flush_cnt_r;

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model of the hazard controller kept in this file.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Behavioural model state
  bit m_wait;   // a memory access is being waited on
  int m_waited; // unserved cycles spent waiting after the first freeze cycle
  bit m_tout;
  int m_stall;
  int m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input bit memread, input int rt, input int rs, input int ifrt,
                        input bit br, input bit jmp, input bit req, input bit rdy,
                        input bit clr);
    bus.idex_memread_i = memread;
    bus.idex_rt_i      = 5'(rt);
    bus.ifid_rs_i      = 5'(rs);
    bus.ifid_rt_i      = 5'(ifrt);
    bus.branch_taken_i = br;
    bus.jump_i         = jmp;
    bus.dmem_req_i     = req;
    bus.dmem_ready_i   = rdy;
    bus.stats_clr_i    = clr;
  endtask

  task automatic idle();
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // One clock cycle: inputs are already applied (at posedge+1). Checks the
  // combinational controls mid-cycle, advances the model, then checks the
  // registered outputs just after the edge.
  task automatic cycle();
    bit fz, lu, br;
    bit e_pc, e_ifw, e_fl, e_keep, e_pipe;
    #2;
    fz = 1'b0; lu = 1'b0; br = 1'b0;
    if (rst) begin
      {e_pc, e_ifw, e_fl, e_keep, e_pipe} = 5'b00000;
    end else begin
      if (m_wait) fz = !bus.dmem_ready_i;
      else        fz = bus.dmem_req_i && !bus.dmem_ready_i;
      lu = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
           (bus.idex_rt_i == bus.ifid_rs_i || bus.idex_rt_i == bus.ifid_rt_i);
      br = bus.branch_taken_i || bus.jump_i;
      if (fz)      {e_pc, e_ifw, e_fl, e_keep, e_pipe} = 5'b00010;
      else if (lu) {e_pc, e_ifw, e_fl, e_keep, e_pipe} = 5'b00001;
      else if (br) {e_pc, e_ifw, e_fl, e_keep, e_pipe} = 5'b11111;
      else         {e_pc, e_ifw, e_fl, e_keep, e_pipe} = 5'b11011;
    end
    check("pc_write",   32'(bus.pc_write_o),   32'(e_pc));
    check("ifid_write", 32'(bus.ifid_write_o), 32'(e_ifw));
    check("ifid_flush", 32'(bus.ifid_flush_o), 32'(e_fl));
    check("ctrl_keep",  32'(bus.ctrl_keep_o),  32'(e_keep));
    check("pipe_write", 32'(bus.pipe_write_o), 32'(e_pipe));

    if (rst) begin
      m_wait = 1'b0; m_waited = 0; m_tout = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_wait) begin
        if (!bus.dmem_ready_i) begin
          m_waited++;
          if (m_waited == MAX_WAIT) m_tout = 1'b1;
        end else begin
          m_wait = 1'b0;
        end
      end else if (bus.dmem_req_i && !bus.dmem_ready_i) begin
        m_wait   = 1'b1;
        m_waited = 0;
      end
      if (bus.stats_clr_i) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (!e_pc) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
        if (e_fl)  m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      end
    end

    @(posedge clk);
    #1;
    check("mem_timeout", 32'(bus.mem_timeout_o), 32'(m_tout));
    check("stall_cnt",   32'(bus.stall_cnt_o),   32'(m_stall));
    check("flush_cnt",   32'(bus.flush_cnt_o),   32'(m_flush));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int ready_pct;
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    // Reset state, two cycles
    cycle();
    cycle();
    rst = 1'b0;
    check("reset_stall_cnt", 32'(bus.stall_cnt_o), 32'd0);
    check("reset_timeout",   32'(bus.mem_timeout_o), 32'd0);

    // Load-use on rs
    set_in(1'b1, 8, 8, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    idle();
    check("lu_stall_cnt_1", 32'(bus.stall_cnt_o), 32'd1);
    cycle();

    // Load to r0 never stalls
    set_in(1'b1, 0, 5, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    idle();
    check("r0_no_stall", 32'(bus.stall_cnt_o), 32'd1);

    // Branch suppressed by load-use, then taken alone
    reset_dut();
    set_in(1'b1, 9, 2, 9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    check("br_lu_no_flush", 32'(bus.flush_cnt_o), 32'd0);
    set_in(1'b0, 9, 2, 9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    check("br_flush_cnt_1", 32'(bus.flush_cnt_o), 32'd1);
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle();

    // Memory wait of 4 cycles, release on ready
    reset_dut();
    set_in(1'b1, 4, 4, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle();
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle();
    idle();
    cycle();
    check("memwait_stall_4", 32'(bus.stall_cnt_o), 32'd4);
    check("memwait_no_tout", 32'(bus.mem_timeout_o), 32'd0);

    // Timeout after MAX_WAIT wait cycles, sticky until reset
    reset_dut();
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == MAX_WAIT - 1) check("tout_not_yet", 32'(bus.mem_timeout_o), 32'd0);
      if (i == MAX_WAIT)     check("tout_set",     32'(bus.mem_timeout_o), 32'd1);
    end
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle();
    idle();
    cycle();
    check("tout_sticky", 32'(bus.mem_timeout_o), 32'd1);
    reset_dut();
    check("tout_cleared", 32'(bus.mem_timeout_o), 32'd0);

    // Counter saturation and clear-over-increment
    set_in(1'b1, 7, 1, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle();
    check("stall_saturate", 32'(bus.stall_cnt_o), 32'(CNT_MAX));
    bus.stats_clr_i = 1'b1;
    cycle();
    check("stall_clear_wins", 32'(bus.stall_cnt_o), 32'd0);

    // Reset during MEM_WAIT aborts the wait
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle();
    bus.dmem_ready_i = 1'b0;
    cycle();
    check("post_reset_run", 32'(bus.stall_cnt_o), 32'd0);

    // Randomized traffic
    ready_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) ready_pct = $urandom_range(5, 90);
      rst = ($urandom_range(0, 149) == 0);
      set_in($urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 99) < ready_pct,
             $urandom_range(0, 39) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
